// File: rtl/crc32_pkg.sv
// Shared constants, lookup-table generators and word type for the CRC-32 FCS engine.
// The tables are built at elaboration, so no memory-initialisation files are needed.
package crc32_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int CRC_WIDTH  = 32;
   localparam int NUM_LANES  = DATA_WIDTH / 8;

   localparam logic [31:0] CRC_POLY  = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

   typedef logic [255:0][31:0] crc_tbl_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [NUM_LANES-1:0]  valid;
   } crc_word_t;

   // Standard reflected table: entry i is i pushed through eight shift/xor steps.
   function automatic crc_tbl_t gen_t0();
      crc_tbl_t    t;
      logic [31:0] c;
      for (int i = 0; i < 256; i++) begin
         c = 32'(i);
         for (int j = 0; j < 8; j++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
         t[i] = c;
      end
      return t;
   endfunction

   // Each slicing table is the previous one advanced by one more zero byte.
   function automatic crc_tbl_t gen_next(input crc_tbl_t prev, input crc_tbl_t t0);
      crc_tbl_t t;
      for (int i = 0; i < 256; i++)
         t[i] = (prev[i] >> 8) ^ t0[prev[i][7:0]];
      return t;
   endfunction

   localparam crc_tbl_t CRC_T0 = gen_t0();
   localparam crc_tbl_t CRC_T1 = gen_next(CRC_T0, CRC_T0);
   localparam crc_tbl_t CRC_T2 = gen_next(CRC_T1, CRC_T0);
   localparam crc_tbl_t CRC_T3 = gen_next(CRC_T2, CRC_T0);

endpackage

// File: rtl/crc32_byte_update.sv
// Folds a single byte into a reflected CRC-32 state using the base lookup table.
module crc32_byte_update
   import crc32_pkg::*;
(
   input  logic [31:0] s_i,
   input  logic [7:0]  b_i,
   output logic [31:0] s_o
);

   logic [7:0] idx;

   assign idx = s_i[7:0] ^ b_i;
   assign s_o = (s_i >> 8) ^ CRC_T0[idx];

endmodule

// File: rtl/crc32.sv
// Combinational CRC-32 word update: slicing-by-4 for full words, a serial
// byte chain for trailing partial words. The caller owns the state register.
module crc32
   import crc32_pkg::*;
#(
   parameter int DATA_WIDTH = crc32_pkg::DATA_WIDTH,
   parameter int CRC_WIDTH  = crc32_pkg::CRC_WIDTH
) (
   input  logic                    clk,
   input  logic                    i_reset_n,
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic [CRC_WIDTH-1:0]    i_crc_state,
   input  logic [DATA_WIDTH/8-1:0] i_data_valid,
   output logic [DATA_WIDTH-1:0]   o_crc,
   output logic [CRC_WIDTH-1:0]    o_crc_state
);

   crc_word_t          word;
   logic [3:0][31:0]   chain;
   logic [31:0]        x;
   logic [31:0]        full_state;
   logic [31:0]        state_d;
   logic               unused_ok;

   // No state lives here; clock and reset are kept only for interface parity.
   assign unused_ok = clk ^ i_reset_n;

   assign word     = '{data: i_data, valid: i_data_valid};
   assign chain[0] = i_crc_state;

   for (genvar k = 0; k < 3; k++) begin : g_lane
      crc32_byte_update u_upd (
         .s_i (chain[k]),
         .b_i (word.data[8*k +: 8]),
         .s_o (chain[k+1])
      );
   end

   // Lane 0 is oldest on the wire, so it needs the most zero-byte advancement (T3).
   assign x          = i_crc_state ^ word.data;
   assign full_state = CRC_T3[x[7:0]] ^ CRC_T2[x[15:8]]
                     ^ CRC_T1[x[23:16]] ^ CRC_T0[x[31:24]];

   // Only the run of set bits starting at lane 0 counts; anything above a hole is dropped.
   always_comb begin
      state_d = i_crc_state;
      casez (word.valid)
         4'b???0: state_d = i_crc_state;
         4'b??01: state_d = chain[1];
         4'b?011: state_d = chain[2];
         4'b0111: state_d = chain[3];
         default: state_d = full_state;
      endcase
   end

   assign o_crc_state = state_d;
   assign o_crc       = state_d ^ CRC_XOROUT;

endmodule

// File: tb/tb_crc32.sv
// Directed and random-frame checks of the CRC-32 engine against a bit-serial model.
module tb_crc32;

   logic        clk;
   logic        i_reset_n;
   logic [31:0] i_data;
   logic [31:0] i_crc_state;
   logic [3:0]  i_data_valid;
   logic [31:0] o_crc;
   logic [31:0] o_crc_state;

   int n_chk;
   int n_fail;

   crc32 dut (
      .clk          (clk),
      .i_reset_n    (i_reset_n),
      .i_data       (i_data),
      .i_crc_state  (i_crc_state),
      .i_data_valid (i_data_valid),
      .o_crc        (o_crc),
      .o_crc_state  (o_crc_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   // Bit-serial reference, independent of any table.
   function automatic logic [31:0] ref_byte(input logic [31:0] s, input logic [7:0] b);
      logic [31:0] c;
      c = s ^ {24'h0, b};
      for (int j = 0; j < 8; j++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   // Drive one word away from the clock edge, then capture the new state as the caller would.
   task automatic apply(input logic [31:0] st, input logic [31:0] d, input logic [3:0] v,
                        output logic [31:0] nst);
      @(negedge clk);
      i_crc_state  = st;
      i_data       = d;
      i_data_valid = v;
      #1;
      nst = o_crc_state;
   endtask

   logic [31:0] st, ref_s, d, tmp;
   logic [3:0]  v;
   int          len, nb;

   initial begin
      n_chk = 0; n_fail = 0;
      i_reset_n = 1'b0; i_data = '0; i_crc_state = 32'hFFFFFFFF; i_data_valid = '0;

      // Reset: outputs still track inputs
      apply(32'hFFFFFFFF, 32'h0, 4'b0000, st);
      chk("reset_state", o_crc_state, 32'hFFFFFFFF);
      chk("reset_crc", o_crc, 32'h00000000);
      @(posedge clk);
      i_reset_n = 1'b1;

      // "123456789" check value and residue
      apply(32'hFFFFFFFF, 32'h34333231, 4'b1111, st);
      apply(st, 32'h38373635, 4'b1111, st);
      apply(st, 32'h00000039, 4'b0001, st);
      chk("check_123456789", o_crc, 32'hCBF43926);
      apply(st, 32'hCBF43926, 4'b1111, st);
      chk("residue", o_crc_state, 32'hDEBB20E3);

      // Single bytes and zero word
      apply(32'hFFFFFFFF, 32'h00000061, 4'b0001, st);
      chk("byte_a", o_crc, 32'hE8B7BE43);
      apply(32'hFFFFFFFF, 32'h00000000, 4'b1111, st);
      chk("zero_word", o_crc, 32'h2144DF1C);
      apply(32'hFFFFFFFF, 32'h00000000, 4'b0001, st);
      chk("zero_byte", o_crc, 32'hD202EF8D);

      // Pass-through
      apply(32'h12345678, 32'hDEADBEEF, 4'b0000, st);
      chk("pass_state", o_crc_state, 32'h12345678);
      chk("pass_crc", o_crc, 32'hEDCBA987);
      apply(32'hA5A5_0F0F, 32'hFFFFFFFF, 4'b0000, st);
      chk("pass_state2", o_crc_state, 32'hA5A50F0F);

      // Two and three byte partial words, garbage in dead lanes
      tmp = ref_byte(ref_byte(32'hFFFFFFFF, 8'h31), 8'h32);
      apply(32'hFFFFFFFF, 32'hEEFF3231, 4'b0011, st);
      chk("two_bytes", o_crc_state, tmp);
      tmp = ref_byte(tmp, 8'h33);
      apply(32'hFFFFFFFF, 32'h77333231, 4'b0111, st);
      chk("three_bytes", o_crc_state, tmp);

      // Non-contiguous masks: only the low contiguous run is used
      apply(32'hFFFFFFFF, 32'h44333231, 4'b1101, st);
      chk("mask_1101", o_crc_state, ref_byte(32'hFFFFFFFF, 8'h31));
      apply(32'hFFFFFFFF, 32'h44333231, 4'b1011, st);
      chk("mask_1011", o_crc_state, ref_byte(ref_byte(32'hFFFFFFFF, 8'h31), 8'h32));
      apply(32'hFFFFFFFF, 32'h44333231, 4'b1110, st);
      chk("mask_1110", o_crc_state, 32'hFFFFFFFF);

      // Random frames; last-word fill cycles through 4,3,2,1 bytes
      for (int it = 0; it < 50; it++) begin
         len   = 4 * int'($urandom_range(2, 375)) - (it % 4);
         st    = 32'hFFFFFFFF;
         ref_s = 32'hFFFFFFFF;
         while (len > 0) begin
            nb = (len >= 4) ? 4 : len;
            d  = $urandom;
            v  = 4'((1 << nb) - 1);
            for (int k = 0; k < nb; k++)
               ref_s = ref_byte(ref_s, d[8*k +: 8]);
            apply(st, d, v, st);
            len -= nb;
         end
         chk($sformatf("frame%0d", it), o_crc, ~ref_s);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/crc32.md
Name: crc32

Overview:
Combinational CRC-32 update engine for the 10G Ethernet MAC TX/RX FCS path. Uses the IEEE 802.3 reflected polynomial 0xEDB88320 with slicing-by-4 lookup tables. Folds one 32-bit data word with a per-byte valid mask into a running CRC state. The caller holds the state register, resets it to 0xFFFFFFFF at start of frame, and feeds o_crc_state back as i_crc_state each cycle.

Parameters:
DATA_WIDTH, 32, data word width in bits; only 32 is supported (4 byte lanes).
CRC_WIDTH, 32, CRC state width in bits; only 32 is supported.

Ports:
clk  input  1  clock; reserved, the datapath is combinational.
i_reset_n  input  1  reset, synchronous, active-low; reserved, no internal state.
i_data  input  DATA_WIDTH  data word; byte lane k = i_data[8k+7:8k]; lane 0 is first on the wire.
i_crc_state  input  CRC_WIDTH  running CRC state (un-inverted register value).
i_data_valid  input  DATA_WIDTH/8  per-byte valid, one bit per lane.
o_crc  output  DATA_WIDTH  finalised CRC = o_crc_state ^ 0xFFFFFFFF.
o_crc_state  output  CRC_WIDTH  updated CRC state after consuming the valid bytes.

Behaviour:
- Interface: reset i_reset_n, synchronous, active-low; clock clk.
- No internal registers. Latency is 0: outputs are a pure function of i_data, i_crc_state and i_data_valid within the same cycle.
- Reset does not alter outputs. The caller's state register must load 0xFFFFFFFF on reset and at start of frame.
- Byte update primitive: s' = (s >> 8) ^ T0[(s ^ b) & 0xFF].
- T0 is the standard reflected CRC-32 table, so T0[1] = 0x77073096.
- Derived tables: Tk[i] = (Tk-1[i] >> 8) ^ T0[Tk-1[i] & 0xFF], for k = 1..3.
- Valid mask 4'b1111 (full word), slicing-by-4:
  - x = i_crc_state ^ i_data.
  - o_crc_state = T3[x[7:0]] ^ T2[x[15:8]] ^ T1[x[23:16]] ^ T0[x[31:24]].
- Valid mask 4'b0111 / 4'b0011 / 4'b0001: apply the byte primitive serially to lanes 0..n-1 in order (3 / 2 / 1 bytes).
- Valid mask 4'b0000: o_crc_state = i_crc_state (pass-through).
- Only contiguous-from-lane-0 masks are legal. For any other mask, only the lowest run of contiguous set bits starting at lane 0 is processed; lanes above the first zero are ignored.
- Result must be bit-exact with a bytewise CRC-32 over the same byte stream. Packing order: each word's bytes lane 0 first, full words before the final partial word.
- o_crc is valid on every cycle. On the cycle the last word is presented it equals the standard Ethernet CRC-32 of the frame, e.g. "123456789" -> 0xCBF43926.
- Residue property: running frame plus its transmitted FCS (LSB byte first) leaves o_crc_state = 0xDEBB20E3.

Decomposition:
- Package crc32_pkg:
  - DATA_WIDTH, CRC_WIDTH defaults.
  - Polynomial constant 0xEDB88320.
  - Init value 0xFFFFFFFF and final XOR 0xFFFFFFFF.
  - Constant functions generating T0..T3 at elaboration (no $readmemh in RTL).
  - Word typedef: data word plus 4-bit valid.
- Sub-module crc32_byte_update: one-byte update s' from (s, b) via T0. Instantiated for the 1/2/3-byte chains; the full-word path uses the 4-table XOR.

Test Plan:
- i_crc_state=0xFFFFFFFF, words 0x34333231 (1111), 0x38373635 (1111), 0x00000039 (0001), state fed back each clk -> final o_crc = 0xCBF43926.
- Single byte 0x61 ("a"), valid 0001, state 0xFFFFFFFF -> o_crc = 0xE8B7BE43.
- Word 0x00000000 valid 1111 from 0xFFFFFFFF -> o_crc = 0x2144DF1C. Single byte 0x00 valid 0001 -> o_crc = 0xD202EF8D.
- Any i_crc_state with valid 0000 -> o_crc_state == i_crc_state; o_crc == ~i_crc_state.
- Residue: the "123456789" frame followed by FCS bytes 0x26,0x39,0xF4,0xCB -> o_crc_state = 0xDEBB20E3.
- Random frames of 4-1500 bytes, last-word masks 0001/0011/0111/1111, 50 iterations -> o_crc matches bytewise reference CRC-32 every frame.
